// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the table-SRAM lookup controller: default widths,
// response-buffer depth, response record and the SECDED(39,32) code tables.
package sram_ctrl_pkg;

    localparam int SRAM_AW    = 11;
    localparam int SRAM_DW    = 39;
    localparam int LK_TW      = 8;
    localparam int RESP_DEPTH = 2;

    localparam int SECDED_K = 32;
    localparam int SECDED_R = 7;

    typedef struct packed {
        logic [SRAM_DW-1:0] data;
        logic [LK_TW-1:0]   tag;
        logic               corr;
        logic               uerr;
    } resp_t;

    typedef logic [SECDED_K-1:0][5:0] synpos_t;
    typedef logic [5:0][SECDED_K-1:0] pmask_t;

    // Data bit j owns the j-th Hamming position that is not a power of two (3,5,6,7,9..38).
    function automatic synpos_t gen_syn_pos();
        synpos_t r;
        int p;
        r = '0;
        p = 3;
        for (int j = 0; j < SECDED_K; j++) begin
            while ((p & (p - 1)) == 0) p++;
            r[j] = 6'(p);
            p++;
        end
        return r;
    endfunction

    function automatic pmask_t gen_pmask();
        synpos_t pos;
        pmask_t  r;
        pos = gen_syn_pos();
        r   = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < SECDED_K; j++)
                r[i][j] = pos[j][i];
        return r;
    endfunction

    localparam synpos_t SYN_POS     = gen_syn_pos();
    localparam pmask_t  PARITY_MASK = gen_pmask();

endpackage

// File: rtl/sram_secded.sv
// Combinational SECDED(39,32) codec: codeword = {overall parity, 6 Hamming checks, data}.
// Only instantiated when SRAM_LOOKUP_CTRL_ECC_EN is defined.
module sram_secded
    import sram_ctrl_pkg::*;
(
    input  logic [31:0] enc_data,
    output logic [38:0] enc_cw,
    input  logic [38:0] dec_cw,
    output logic [31:0] dec_data,
    output logic        dec_corr,
    output logic        dec_uerr
);

    logic [5:0] enc_chk;
    logic [5:0] syn;
    logic       overall;
    logic       hit;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : gen_chk
            assign enc_chk[gi] = ^(enc_data & PARITY_MASK[gi]);
            assign syn[gi]     = (^(dec_cw[31:0] & PARITY_MASK[gi])) ^ dec_cw[32+gi];
        end
    endgenerate

    assign enc_cw  = {^{enc_chk, enc_data}, enc_chk, enc_data};
    assign overall = ^dec_cw;

    // Odd overall parity means one flipped bit; the syndrome must then name a real position.
    always_comb begin
        dec_data = dec_cw[31:0];
        hit      = (syn == 6'd0);
        for (int i = 0; i < 6; i++)
            if (syn == 6'(1 << i)) hit = 1'b1;
        for (int j = 0; j < SECDED_K; j++) begin
            if (syn == SYN_POS[j]) begin
                hit = 1'b1;
                if (overall) dec_data[j] = ~dec_cw[j];
            end
        end
        dec_corr = overall && hit;
        dec_uerr = (overall && !hit) || (!overall && (syn != 6'd0));
    end

endmodule

// File: rtl/sram_lookup_ctrl.sv
// Arbitrates lookups and table updates onto a single-port SRAM and returns read words
// through a 2-entry response buffer. Define SRAM_LOOKUP_CTRL_ECC_EN for SECDED storage.
module sram_lookup_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW       = SRAM_AW,
    parameter int DW       = SRAM_DW,
    parameter int TW       = LK_TW,
    parameter int UP_BURST = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          lk_valid,
    output logic          lk_ready,
    input  logic [AW-1:0] lk_addr,
    input  logic [TW-1:0] lk_tag,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [AW-1:0] up_addr,
    input  logic [DW-1:0] up_data,
    output logic          rs_valid,
    input  logic          rs_ready,
    output logic [DW-1:0] rs_data,
    output logic [TW-1:0] rs_tag,
    output logic          rs_corr,
    output logic          rs_uerr,
    output logic [AW-1:0] ADR,
    output logic [DW-1:0] D,
    output logic          WE,
    input  logic [DW-1:0] Q
);

    localparam int BW = $clog2(UP_BURST + 1);

    resp_t          entry_reg [RESP_DEPTH];
    logic           wr_ptr_reg;
    logic           rd_ptr_reg;
    logic [1:0]     count_reg;
    logic           inflight_reg;
    logic [TW-1:0]  tag_reg;
    logic [BW-1:0]  burst_reg;

    logic           pop;
    logic           push;
    logic [2:0]     occ;
    logic           lk_elig;
    logic           force_lk;
    logic           grant_up;
    logic           grant_lk;
    logic [DW-1:0]  wr_word;
    resp_t          push_resp;
    resp_t          head;

    assign rs_valid = (count_reg != 2'd0);
    assign pop      = rs_valid && rs_ready;
    assign push     = inflight_reg;

    // Credit check: the read issued now lands next cycle, so count it against the buffer.
    assign occ      = {1'b0, count_reg} + {2'b0, inflight_reg} - {2'b0, pop};
    assign lk_elig  = RST_N && lk_valid && (occ < 3'd2);
    assign force_lk = (burst_reg == BW'(UP_BURST));
    assign grant_up = RST_N && up_valid && !(lk_elig && force_lk);
    assign grant_lk = lk_elig && !grant_up;

    assign up_ready = grant_up;
    assign lk_ready = grant_lk;
    assign WE       = grant_up;
    assign ADR      = grant_lk ? lk_addr : (grant_up ? up_addr : '0);
    assign D        = grant_up ? wr_word : '0;

`ifdef SRAM_LOOKUP_CTRL_ECC_EN
    logic [31:0] dec_data;
    logic        dec_corr;
    logic        dec_uerr;

    sram_secded u_secded (
        .enc_data (up_data[31:0]),
        .enc_cw   (wr_word),
        .dec_cw   (Q),
        .dec_data (dec_data),
        .dec_corr (dec_corr),
        .dec_uerr (dec_uerr)
    );

    assign push_resp = '{data: {{(DW-32){1'b0}}, dec_data}, tag: tag_reg,
                         corr: dec_corr, uerr: dec_uerr};
`else
    assign wr_word   = up_data;
    assign push_resp = '{data: Q, tag: tag_reg, corr: 1'b0, uerr: 1'b0};
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            inflight_reg <= 1'b0;
            tag_reg      <= '0;
            burst_reg    <= '0;
        end else begin
            inflight_reg <= grant_lk;
            if (grant_lk) tag_reg <= lk_tag;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);
            if (grant_lk || !lk_elig)
                burst_reg <= '0;
            else if (grant_up)
                burst_reg <= burst_reg + BW'(1);
        end
    end

    // Storage needs no reset: outputs are masked by rs_valid.
    always_ff @(posedge CLK) begin
        if (push) entry_reg[wr_ptr_reg] <= push_resp;
    end

    assign head    = entry_reg[rd_ptr_reg];
    assign rs_data = rs_valid ? head.data : '0;
    assign rs_tag  = rs_valid ? head.tag  : '0;
    assign rs_corr = rs_valid && head.corr;
    assign rs_uerr = rs_valid && head.uerr;

endmodule

// File: tb/tb_sram_lookup_ctrl.sv
// Directed bench for sram_lookup_ctrl with a behavioural 2048x39 SRAM (registered Q).
// Builds with or without SRAM_LOOKUP_CTRL_ECC_EN.
module tb_sram_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid, lk_ready, up_valid, up_ready;
    logic [10:0] lk_addr, up_addr, adr;
    logic [7:0]  lk_tag, rs_tag;
    logic [38:0] up_data, rs_data, d, q, q_reg, q_flip;
    logic        rs_valid, rs_ready, rs_corr, rs_uerr, we;
    logic [38:0] mem [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [10:0] addr;
        logic [38:0] wdata;
        logic [7:0]  tag;
        logic [38:0] exp;
    } vec_t;

    typedef struct {
        logic [38:0] data;
        logic [7:0]  tag;
    } exp_t;

    vec_t vecs [5];
    exp_t expq [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[adr] <= d;
        q_reg <= mem[adr];
    end
    assign q = q_reg ^ q_flip;

    sram_lookup_ctrl dut (
        .CLK(clk), .RST_N(rst_n),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_tag(lk_tag),
        .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_data(up_data),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data), .rs_tag(rs_tag),
        .rs_corr(rs_corr), .rs_uerr(rs_uerr),
        .ADR(adr), .D(d), .WE(we), .Q(q)
    );

    function automatic logic [38:0] expw(input logic [38:0] w);
`ifdef SRAM_LOOKUP_CTRL_ECC_EN
        return {7'b0, w[31:0]};
`else
        return w;
`endif
    endfunction

    function automatic logic [38:0] sdata(input int i);
        return 39'(32'h1000_0000 + 32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [10:0] a, input logic [38:0] w);
        int waited;
        up_valid = 1'b1; up_addr = a; up_data = w;
        waited = 0;
        @(negedge clk);
        while (!up_ready && waited < 8) begin
            next_cycle();
            @(negedge clk);
            waited++;
        end
        chk("up_grant", 64'(up_ready), 64'(1));
        chk("up_we", 64'(we), 64'(1));
        chk("up_adr", 64'(adr), 64'(a));
`ifndef SRAM_LOOKUP_CTRL_ECC_EN
        chk("up_d", 64'(d), 64'(w));
`endif
        $display("update addr=%03h data=%010h", a, w);
        next_cycle();
        up_valid = 1'b0;
    endtask

    task automatic lookup_single(input logic [10:0] a, input logic [7:0] t,
                                 input logic [38:0] exp, input logic ec, input logic eu);
        lk_valid = 1'b1; lk_addr = a; lk_tag = t;
        @(negedge clk);
        chk("lk_grant", 64'(lk_ready), 64'(1));
        chk("lk_we", 64'(we), 64'(0));
        chk("lk_adr", 64'(adr), 64'(a));
        next_cycle();
        lk_valid = 1'b0;
        @(negedge clk);
        chk("rs_early", 64'(rs_valid), 64'(0));
        @(negedge clk);
        chk("rs_valid", 64'(rs_valid), 64'(1));
        chk("rs_data", 64'(rs_data), 64'(exp));
        chk("rs_tag", 64'(rs_tag), 64'(t));
        chk("rs_corr", 64'(rs_corr), 64'(ec));
        chk("rs_uerr", 64'(rs_uerr), 64'(eu));
        $display("lookup addr=%03h tag=%02h data=%010h corr=%0d uerr=%0d",
                 a, t, rs_data, rs_corr, rs_uerr);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int next_addr;
        int budget;

        vecs[0] = '{11'h005, 39'h00_1234_5678, 8'h3C, 39'h00_1234_5678};
        vecs[1] = '{11'h000, 39'h7F_0000_0001, 8'h01, 39'h7F_0000_0001};
        vecs[2] = '{11'h400, 39'h55_AAAA_5555, 8'hFF, 39'h55_AAAA_5555};
        vecs[3] = '{11'h7FE, 39'h00_0000_0000, 8'h00, 39'h00_0000_0000};
        vecs[4] = '{11'h123, 39'h2A_CAFE_F00D, 8'hA5, 39'h2A_CAFE_F00D};

        // Reset: handshakes and SRAM pins gated even with both requests asserted.
        rst_n = 1'b0; q_flip = '0; rs_ready = 1'b1;
        lk_valid = 1'b1; lk_addr = 11'h155; lk_tag = 8'h99;
        up_valid = 1'b1; up_addr = 11'h2AA; up_data = 39'h12_3456_789A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lk_ready", 64'(lk_ready), 64'(0));
        chk("rst_up_ready", 64'(up_ready), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_adr", 64'(adr), 64'(0));
        chk("rst_d", 64'(d), 64'(0));
        chk("rst_rs_valid", 64'(rs_valid), 64'(0));
        chk("rst_rs_data", 64'(rs_data), 64'(0));
        chk("rst_rs_tag", 64'(rs_tag), 64'(0));
        next_cycle();
        lk_valid = 1'b0; up_valid = 1'b0; rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 5; i++) begin
            do_update(vecs[i].addr, vecs[i].wdata);
            lookup_single(vecs[i].addr, vecs[i].tag, expw(vecs[i].exp), 1'b0, 1'b0);
        end

        // Streaming: 16 back-to-back lookups, results on consecutive cycles.
        for (int i = 0; i < 16; i++) do_update(11'(i), sdata(i));
        rs_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            lk_valid = (c < 16); lk_addr = 11'(c); lk_tag = 8'(8'h80 + c);
            @(negedge clk);
            chk("stream_lk_ready", 64'(lk_ready), 64'(c < 16));
            chk("stream_rs_valid", 64'(rs_valid), 64'((c >= 2) && (c < 18)));
            if ((c >= 2) && (c < 18)) begin
                chk("stream_data", 64'(rs_data), 64'(expw(sdata(c - 2))));
                chk("stream_tag", 64'(rs_tag), 64'(8'h80 + c - 2));
                $display("stream result tag=%02h data=%010h", rs_tag, rs_data);
            end
            next_cycle();
        end
        lk_valid = 1'b0;

        // Backpressure: only two lookups fit while results are blocked.
        rs_ready = 1'b0; next_addr = 0;
        for (int c = 0; c < 6; c++) begin
            lk_valid = 1'b1; lk_addr = 11'(next_addr); lk_tag = 8'(8'h40 + next_addr);
            @(negedge clk);
            if (lk_ready) begin
                expq.push_back('{expw(sdata(next_addr)), 8'(8'h40 + next_addr)});
                next_addr++;
            end
            next_cycle();
        end
        @(negedge clk);
        chk("bp_accepted", 64'(next_addr), 64'(2));
        chk("bp_lk_ready", 64'(lk_ready), 64'(0));
        chk("bp_rs_valid", 64'(rs_valid), 64'(1));
        chk("bp_hold_data", 64'(rs_data), 64'(expw(sdata(0))));
        chk("bp_hold_tag", 64'(rs_tag), 64'(8'h40));
        next_cycle();
        rs_ready = 1'b1; budget = 0;
        while ((next_addr < 6 || expq.size() > 0) && budget < 40) begin
            lk_valid = (next_addr < 6); lk_addr = 11'(next_addr);
            lk_tag = 8'(8'h40 + next_addr);
            @(negedge clk);
            if (rs_valid && rs_ready) begin
                chk("bp_expected_pending", 64'(expq.size() != 0), 64'(1));
                if (expq.size() != 0) begin
                    chk("bp_data", 64'(rs_data), 64'(expq[0].data));
                    chk("bp_tag", 64'(rs_tag), 64'(expq[0].tag));
                    $display("bp result tag=%02h data=%010h", rs_tag, rs_data);
                    void'(expq.pop_front());
                end
            end
            if (lk_ready) begin
                expq.push_back('{expw(sdata(next_addr)), 8'(8'h40 + next_addr)});
                next_addr++;
            end
            next_cycle();
            budget++;
        end
        lk_valid = 1'b0;
        chk("bp_all_issued", 64'(next_addr), 64'(6));
        chk("bp_drained", 64'(expq.size()), 64'(0));

        // Fairness: U,U,U,U,L repeating under continuous contention.
        up_valid = 1'b1; up_addr = 11'h7F0; up_data = 39'h1;
        lk_valid = 1'b1; lk_addr = 11'h000; lk_tag = 8'hEE;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("fair_up", 64'(up_ready), 64'((c % 5) != 4));
            chk("fair_lk", 64'(lk_ready), 64'((c % 5) == 4));
            $display("fair cycle %0d grant=%s", c, lk_ready ? "L" : (up_ready ? "U" : "-"));
            next_cycle();
        end
        up_valid = 1'b0; lk_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("fair_drained", 64'(rs_valid), 64'(0));
        next_cycle();

        // Read-after-write in the following cycle sees the new word.
        do_update(11'h7FF, 39'h00_5A5A_5A5A);
        lookup_single(11'h7FF, 8'h11, expw(39'h00_5A5A_5A5A), 1'b0, 1'b0);

`ifdef SRAM_LOOKUP_CTRL_ECC_EN
        do_update(11'h0AA, 39'h7F_DEAD_BEEF);
        q_flip = 39'h8;
        lookup_single(11'h0AA, 8'h21, 39'h00_DEAD_BEEF, 1'b1, 1'b0);
        q_flip = 39'h2_0008;
        lookup_single(11'h0AA, 8'h22, 39'h00_DEAF_BEE7, 1'b0, 1'b1);
        q_flip = '0;
`endif

        // Reset with a read in flight: the result must never appear.
        lk_valid = 1'b1; lk_addr = 11'h005; lk_tag = 8'h77;
        @(negedge clk);
        chk("inflight_grant", 64'(lk_ready), 64'(1));
        next_cycle();
        rst_n = 1'b0; up_valid = 1'b1;
        @(negedge clk);
        chk("rstlow_lk_ready", 64'(lk_ready), 64'(0));
        chk("rstlow_up_ready", 64'(up_ready), 64'(0));
        chk("rstlow_we", 64'(we), 64'(0));
        next_cycle();
        @(negedge clk);
        chk("rst2_rs_valid", 64'(rs_valid), 64'(0));
        chk("rst2_rs_data", 64'(rs_data), 64'(0));
        chk("rst2_rs_tag", 64'(rs_tag), 64'(0));
        chk("rst2_rs_corr", 64'(rs_corr), 64'(0));
        chk("rst2_rs_uerr", 64'(rs_uerr), 64'(0));
        next_cycle();
        lk_valid = 1'b0; up_valid = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_rs_valid", 64'(rs_valid), 64'(0));
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
